// File: rtl/warmboot_pkg.sv
// Shared types and constants for the SB_WARMBOOT request sequencer.
package warmboot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      SETUP,
      FIRE,
      DONE
   } state_t;

   localparam logic [1:0] IMG0 = 2'b00;
   localparam logic [1:0] IMG1 = 2'b01;
   localparam logic [1:0] IMG2 = 2'b10;
   localparam logic [1:0] IMG3 = 2'b11;

   localparam int DEF_SETUP_CYCLES   = 16;
   localparam int DEF_PULSE_CYCLES   = 4;
   localparam int DEF_CONFIRM_CYCLES = 4194304;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/warmboot_sequencer.sv
// Sequences S1/S0 and BOOT for SB_WARMBOOT from a valid/ready image request.
// Optional two-step confirmation is enabled with `define WARMBOOT_CONFIRM_EN.
module warmboot_sequencer
   import warmboot_pkg::*;
#(
   parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
   parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
   parameter int CONFIRM_CYCLES = DEF_CONFIRM_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [1:0] req_image,
   output logic       req_ready,
   input  logic       cancel,
   output logic       busy,
   output logic       boot_o,
   output logic       s1_o,
   output logic       s0_o
);

   localparam int CW = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, CONFIRM_CYCLES) + 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

   state_t        state, stateNext;
   logic [CW-1:0] count, countNext;
   logic          bootNext;
   logic [1:0]    imgNext;

`ifdef WARMBOOT_CONFIRM_EN
   localparam logic [CW-1:0] CONFIRM_LAST = CW'(CONFIRM_CYCLES - 1);
   logic [1:0] pending, pendingNext;
`endif

   assign req_ready = (state == IDLE) || (state == ARMED);
   assign busy      = (state != IDLE);

   // State, counter and the three SB_WARMBOOT drivers all come straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         count        <= '0;
         boot_o       <= 1'b0;
         {s1_o, s0_o} <= IMG0;
`ifdef WARMBOOT_CONFIRM_EN
         pending      <= IMG0;
`endif
      end else begin
         state        <= stateNext;
         count        <= countNext;
         boot_o       <= bootNext;
         {s1_o, s0_o} <= imgNext;
`ifdef WARMBOOT_CONFIRM_EN
         pending      <= pendingNext;
`endif
      end
   end

   // Next-state logic; in IDLE a handshake always beats cancel.
   always_comb begin
      stateNext = state;
      countNext = count;
      bootNext  = boot_o;
      imgNext   = {s1_o, s0_o};
`ifdef WARMBOOT_CONFIRM_EN
      pendingNext = pending;
`endif
      case (state)
         IDLE: begin
            bootNext = 1'b0;
            if (req_valid) begin
               countNext = '0;
`ifdef WARMBOOT_CONFIRM_EN
               pendingNext = req_image;
               stateNext   = ARMED;
`else
               imgNext   = req_image;
               stateNext = SETUP;
`endif
            end
         end
`ifdef WARMBOOT_CONFIRM_EN
         ARMED: begin
            bootNext = 1'b0;
            if (cancel) begin
               countNext = '0;
               stateNext = IDLE;
            end else if (req_valid) begin
               countNext = '0;
               if (req_image == pending) begin
                  imgNext   = req_image;
                  stateNext = SETUP;
               end else begin
                  pendingNext = req_image;
               end
            end else if (count == CONFIRM_LAST) begin
               countNext = '0;
               stateNext = IDLE;
            end else begin
               countNext = count + 1'b1;
            end
         end
`endif
         SETUP: begin
            bootNext = 1'b0;
            if (cancel) begin
               countNext = '0;
               imgNext   = IMG0;
               stateNext = IDLE;
            end else if (count == SETUP_LAST) begin
               countNext = '0;
               bootNext  = 1'b1;
               stateNext = FIRE;
            end else begin
               countNext = count + 1'b1;
            end
         end
         FIRE: begin
            if (count == PULSE_LAST) begin
               countNext = '0;
               bootNext  = 1'b0;
               stateNext = DONE;
            end else begin
               countNext = count + 1'b1;
            end
         end
         DONE: begin
            bootNext = 1'b0;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

endmodule
